// File: rtl/handshake_defs.sv
// Shared definitions for the req/ack clock-crossing handshake.
// State encodings, default widths and synchroniser depth limits.
package handshake_defs;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  localparam int N_DEF     = 8;
  localparam int CNT_W_DEF = 16;
  localparam int SYNC_DEF  = 2;
  localparam int SYNC_MIN  = 2;
  localparam int SYNC_MAX  = 4;

endpackage

// File: rtl/handshake_sync.sv
// Level synchroniser: STAGES-deep flop chain, sync reset to 0.
// Ports: clk, rst (sync, active high), d (async level), q (synced level).
module handshake_sync
  import handshake_defs::*;
#(
  parameter int STAGES = SYNC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

  if (STAGES < SYNC_MIN || STAGES > SYNC_MAX) begin : g_bad_depth
    $error("handshake_sync: STAGES out of range 2..4");
  end

endmodule

// File: rtl/handshake_receiver.sv
// Receive side of a 4-phase req/ack crossing with a valid/ready output.
// Ports: clk_r, rst, req_in, data_in -> ack_out, data_out, valid, xfer_cnt; ready from consumer.
module handshake_receiver
  import handshake_defs::*;
#(
  parameter int N           = N_DEF,
  parameter int SYNC_STAGES = SYNC_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk_r,
  input  logic             rst,
  input  logic             req_in,
  input  logic [N-1:0]     data_in,
  output logic             ack_out,
  output logic [N-1:0]     data_out,
  output logic             valid,
  input  logic             ready,
  output logic [CNT_W-1:0] xfer_cnt
);

  state_t state;
  state_t state_nx;
  logic   req_s;
  logic   out_free;
  logic   capture;
  logic   pop;

  handshake_sync #(
    .STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clk (clk_r),
    .rst (rst),
    .d   (req_in),
    .q   (req_s)
  );

  // ack is a dedicated flop mirroring the next state, so the
  // sender never sees a combinational glitch.
  always_ff @(posedge clk_r) begin
    if (rst) begin
      state   <= IDLE;
      ack_out <= 1'b0;
    end else begin
      state   <= state_nx;
      ack_out <= (state_nx == ACK);
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (capture) state_nx = ACK;
      ACK:  if (!req_s)  state_nx = IDLE;
    endcase
  end

  // A full, unpopped output slot holds off the capture, which
  // in turn holds off ack and stalls the sender.
  always_comb begin
    out_free = ~valid | ready;
    capture  = (state == IDLE) & req_s & out_free;
    pop      = valid & ready;
  end

  always_ff @(posedge clk_r) begin
    if (rst) begin
      data_out <= '0;
      valid    <= 1'b0;
      xfer_cnt <= '0;
    end else if (capture) begin
      data_out <= data_in;
      valid    <= 1'b1;
      xfer_cnt <= xfer_cnt + 1'b1;
    end else if (pop) begin
      valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_handshake_receiver.sv
// Self-checking bench for handshake_receiver.
// Cycle tables for reset/single/backpressure, random burst with scoreboard.
module tb_handshake_receiver;
  timeunit 1ns;
  timeprecision 100ps;

  logic        clk_r = 1'b0;
  logic        clk_t = 1'b0;
  logic        rst = 1'b1;
  logic        req_in = 1'b0;
  logic        ready = 1'b1;
  logic [7:0]  data_in = 8'h00;
  logic        ack_out;
  logic        valid;
  logic [7:0]  data_out;
  logic [15:0] xfer_cnt;
  logic        w_ack;
  logic        w_valid;
  logic [7:0]  w_data;
  logic [3:0]  w_cnt;

  handshake_receiver #(
    .N (8), .SYNC_STAGES (2), .CNT_W (16)
  ) dut (
    .clk_r    (clk_r),
    .rst      (rst),
    .req_in   (req_in),
    .data_in  (data_in),
    .ack_out  (ack_out),
    .data_out (data_out),
    .valid    (valid),
    .ready    (ready),
    .xfer_cnt (xfer_cnt)
  );

  // Narrow-counter copy watching the same req phases, ready tied high.
  handshake_receiver #(
    .N (8), .SYNC_STAGES (2), .CNT_W (4)
  ) dut_w (
    .clk_r    (clk_r),
    .rst      (rst),
    .req_in   (req_in),
    .data_in  (data_in),
    .ack_out  (w_ack),
    .data_out (w_data),
    .valid    (w_valid),
    .ready    (1'b1),
    .xfer_cnt (w_cnt)
  );

  always #5 clk_r = ~clk_r;
  initial begin
    #0.5;
    forever #7 clk_t = ~clk_t;
  end

  int n_chk  = 0;
  int n_fail = 0;
  int n_pop  = 0;
  bit mon_en = 1'b0;
  bit rand_rdy = 1'b0;
  bit dead = 1'b0;
  logic [7:0] exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic        rst;
    logic        req;
    logic        rdy;
    logic [7:0]  din;
    logic [25:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, input logic q,
                              input logic y, input logic [7:0] d,
                              input logic a, input logic v,
                              input logic [7:0] o,
                              input logic [15:0] c);
    vec_t e;
    e.rst = r;
    e.req = q;
    e.rdy = y;
    e.din = d;
    e.exp = {a, v, o, c};
    tbl.push_back(e);
  endfunction

  // Consumer + scoreboard: a pop happens at the next posedge when
  // valid and ready are both high during this low phase.
  always @(negedge clk_r) begin
    if (rand_rdy) ready = ($urandom_range(0, 3) != 0);
    if (mon_en && valid && ready) begin
      n_pop++;
      if (exp_q.size() == 0)
        chk("pop_extra", 64'(data_out), 64'hFFFF);
      else
        chk("pop_order", 64'(data_out), 64'(exp_q.pop_front()));
    end
  end

  task automatic send(input logic [7:0] w);
    int t;
    @(posedge clk_t);
    data_in = w;
    exp_q.push_back(w);
    @(posedge clk_t);
    req_in = 1'b1;
    t = 0;
    while (ack_out !== 1'b1 && t < 300) begin
      @(posedge clk_t);
      t++;
    end
    if (t >= 300) begin
      chk("ack_rise_timeout", 64'(ack_out), 64'd1);
      dead = 1'b1;
    end
    req_in = 1'b0;
    t = 0;
    while (ack_out !== 1'b0 && t < 300) begin
      @(posedge clk_t);
      t++;
    end
    if (t >= 300) begin
      chk("ack_fall_timeout", 64'(ack_out), 64'd0);
      dead = 1'b1;
    end
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge clk_r);
      t++;
    end
    chk(nm, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int t;
    // T1 reset with req high, T2 single word, T3 backpressure
    for (int i = 0; i < 3; i++)
      add(1, 1, 1, 8'h00, 0, 0, 8'h00, 0);
    add(0, 0, 1, 8'hA5, 0, 0, 8'h00, 0);
    add(0, 1, 1, 8'hA5, 0, 0, 8'h00, 0);
    add(0, 1, 1, 8'hA5, 0, 0, 8'h00, 0);
    add(0, 1, 1, 8'hA5, 1, 1, 8'hA5, 1);
    add(0, 0, 1, 8'hA5, 1, 0, 8'hA5, 1);
    add(0, 0, 1, 8'hA5, 1, 0, 8'hA5, 1);
    add(0, 0, 1, 8'hA5, 0, 0, 8'hA5, 1);
    add(0, 1, 0, 8'h11, 0, 0, 8'hA5, 1);
    add(0, 1, 0, 8'h11, 0, 0, 8'hA5, 1);
    add(0, 1, 0, 8'h11, 1, 1, 8'h11, 2);
    add(0, 0, 0, 8'h11, 1, 1, 8'h11, 2);
    add(0, 0, 0, 8'h11, 1, 1, 8'h11, 2);
    add(0, 1, 0, 8'h22, 0, 1, 8'h11, 2);
    add(0, 1, 0, 8'h22, 0, 1, 8'h11, 2);
    add(0, 1, 0, 8'h22, 0, 1, 8'h11, 2);
    add(0, 1, 0, 8'h22, 0, 1, 8'h11, 2);
    add(0, 1, 1, 8'h22, 1, 1, 8'h22, 3);
    add(0, 0, 0, 8'h22, 1, 1, 8'h22, 3);
    add(0, 0, 1, 8'h22, 1, 0, 8'h22, 3);
    add(0, 0, 1, 8'h22, 0, 0, 8'h22, 3);

    @(negedge clk_r);
    foreach (tbl[i]) begin
      rst     = tbl[i].rst;
      req_in  = tbl[i].req;
      ready   = tbl[i].rdy;
      data_in = tbl[i].din;
      @(negedge clk_r);
      chk($sformatf("vec%0d", i),
          64'({ack_out, valid, data_out, xfer_cnt}),
          64'(tbl[i].exp));
    end

    // T4 random burst with random backpressure
    mon_en = 1'b1;
    rand_rdy = 1'b1;
    for (int i = 0; i < 256; i++)
      if (!dead) send(8'($urandom));
    drain("burst_drain");
    repeat (20) @(negedge clk_r);
    chk("burst_pops", 64'(n_pop), 64'd256);
    chk("burst_cnt", 64'(xfer_cnt), 64'd259);
    chk("wrap_cnt_burst", 64'(w_cnt), 64'd3);

    // T6 reset while in ACK with req still high
    mon_en = 1'b0;
    rand_rdy = 1'b0;
    @(negedge clk_r);
    ready = 1'b1;
    data_in = 8'h5A;
    req_in = 1'b1;
    t = 0;
    while (ack_out !== 1'b1 && t < 20) begin
      @(negedge clk_r);
      t++;
    end
    chk("t6_ack_before", 64'(ack_out), 64'd1);
    rst = 1'b1;
    @(negedge clk_r);
    chk("t6_reset", 64'({ack_out, valid, data_out, xfer_cnt}), 64'd0);
    rst = 1'b0;
    @(negedge clk_r);
    chk("t6_edge1", 64'({ack_out, valid}), 64'd0);
    @(negedge clk_r);
    chk("t6_edge2", 64'({ack_out, valid}), 64'd0);
    @(negedge clk_r);
    chk("t6_recap", 64'({ack_out, valid, data_out, xfer_cnt}),
        64'({1'b1, 1'b1, 8'h5A, 16'd1}));
    chk("t6_no_x",
        64'($isunknown({ack_out, valid, data_out, xfer_cnt})), 64'd0);
    req_in = 1'b0;
    repeat (4) @(negedge clk_r);
    chk("t6_release", 64'({ack_out, valid, xfer_cnt}),
        64'({1'b0, 1'b0, 16'd1}));

    // T5 counter wrap on the 4-bit copy
    rst = 1'b1;
    @(negedge clk_r);
    rst = 1'b0;
    exp_q.delete();
    n_pop = 0;
    mon_en = 1'b1;
    rand_rdy = 1'b1;
    for (int i = 0; i < 17; i++)
      if (!dead) send(8'(i * 7 + 3));
    drain("wrap_drain");
    repeat (10) @(negedge clk_r);
    chk("wrap_pops", 64'(n_pop), 64'd17);
    chk("wrap_main_cnt", 64'(xfer_cnt), 64'd17);
    chk("wrap_cnt", 64'(w_cnt), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
